// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC decimation path (comb and integrator chains).
package cic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } comb_state_t;

  localparam bit QUANT_TRUNC = 1'b0;
  localparam bit QUANT_ROUND = 1'b1;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned chan_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cic_comb_delay_store.sv
// Per-channel, per-stage comb history registers; exposes the oldest tap and shifts in the stage input.
module cic_comb_delay_store
  import cic_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STAGES     = 5,
  parameter int unsigned DIFF_DELAY = 1,
  parameter int unsigned CHANNELS   = 2
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [chan_width(CHANNELS)-1:0]   ch,
  input  logic [chan_width(STAGES)-1:0]     stage,
  input  logic                              shift,
  input  logic [WIDTH-1:0]                  shift_in,
  output logic [WIDTH-1:0]                  tap
);

  logic [WIDTH-1:0] mem [CHANNELS][STAGES][DIFF_DELAY];

  assign tap = mem[ch][stage][DIFF_DELAY-1];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned s = 0; s < STAGES; s++)
          for (int unsigned j = 0; j < DIFF_DELAY; j++)
            mem[c][s][j] <= '0;
    end else if (shift) begin
      for (int unsigned j = DIFF_DELAY - 1; j > 0; j--)
        mem[ch][stage][j] <= mem[ch][stage][j-1];
      mem[ch][stage][0] <= shift_in;
    end
  end

endmodule

// File: rtl/cic_comb_chain.sv
// Multi-stage, multi-channel CIC comb section sharing one subtractor across all stages and channels.
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned STAGES     = 5,
  parameter int unsigned DIFF_DELAY = 1,
  parameter int unsigned CHANNELS   = 2,
  parameter bit          ROUND      = 1'b1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             in_strobe,
  input  logic [chan_width(CHANNELS)-1:0]  in_chan,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             in_ready,
  output logic                             out_strobe,
  output logic [chan_width(CHANNELS)-1:0]  out_chan,
  output logic [OUT_WIDTH-1:0]             out_data,
  output logic                             overrun
);

  localparam int unsigned CW   = chan_width(CHANNELS);
  localparam int unsigned SW   = chan_width(STAGES);
  localparam int unsigned DROP = WIDTH - OUT_WIDTH;
  localparam logic [CW:0] CHAN_LIMIT = (CW+1)'(CHANNELS);

  comb_state_t       state, state_next;
  logic [CW-1:0]     ch;
  logic [SW-1:0]     stage;
  logic [WIDTH-1:0]  acc, tap, diff;
  logic [OUT_WIDTH-1:0] q;
  logic              accept, last;

  assign in_ready = (state == IDLE);
  assign accept   = in_ready && in_strobe && ({1'b0, in_chan} < CHAN_LIMIT);
  assign last     = (stage == SW'(STAGES - 1));
  assign diff     = acc - tap;

  cic_comb_delay_store #(
    .WIDTH      (WIDTH),
    .STAGES     (STAGES),
    .DIFF_DELAY (DIFF_DELAY),
    .CHANNELS   (CHANNELS)
  ) u_store (
    .clock    (clock),
    .reset_n  (reset_n),
    .ch       (ch),
    .stage    (stage),
    .shift    (state == RUN),
    .shift_in (acc),
    .tap      (tap)
  );

  // Rounding adds half an output LSB in one extra bit so a positive overflow is visible.
  generate
    if (DROP == 0) begin : g_pass
      assign q = diff;
    end else if (ROUND == QUANT_TRUNC) begin : g_trunc
      assign q = diff[WIDTH-1:DROP];
    end else begin : g_round
      localparam logic [WIDTH:0] HALF = (WIDTH+1)'(1) << (DROP - 1);
      logic [WIDTH:0] sum;
      assign sum = {diff[WIDTH-1], diff} + HALF;
      assign q   = (sum[WIDTH] != sum[WIDTH-1]) ? {1'b0, {(OUT_WIDTH-1){1'b1}}}
                                                : sum[WIDTH-1:DROP];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc        <= '0;
      ch         <= '0;
      stage      <= '0;
      out_strobe <= 1'b0;
      out_chan   <= '0;
      out_data   <= '0;
      overrun    <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      if (in_strobe && !in_ready) overrun <= 1'b1;
      if (accept) begin
        acc   <= in_data;
        ch    <= in_chan;
        stage <= '0;
      end else if (state == RUN) begin
        acc <= diff;
        if (last) begin
          out_strobe <= 1'b1;
          out_chan   <= ch;
          out_data   <= q;
        end else begin
          stage <= stage + SW'(1);
        end
      end
    end
  end

endmodule
